// File: rtl/keys_pio_service_ctrl.sv
// -----------------------------------------------------------------------------
// keys_pio_service_ctrl
//
// Avalon-MM master that owns the 4-bit key PIO (data @0, IRQ mask @2, edge
// capture @3). After reset it programs the IRQ mask. On pio_irq it reads and
// clears the edge capture and then samples the key levels. Each captured edge
// becomes a {key, pressed} event in a small FIFO for the note logic.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   m_address/chipselect/ single-cycle PIO accesses (no waitrequest); read
//   m_write_n/writedata   data returns one cycle after the address
//   m_readdata            PIO read data, only [3:0] is meaningful
//   pio_irq               PIO interrupt request
//   cfg_mask/_load        strobe to request a new IRQ mask write
//   ev_valid/ev_ready     event FIFO head; a pop is ev_valid & ev_ready
//   ev_key/ev_pressed     head event (pressed = key level 0, keys active-low)
//   ev_overflow/_clr      sticky drop flag and its clear (a drop wins)
//   busy                  high in every state except IDLE
//   dbg_state_o           current FSM state, for debug and checkers
//
// Event handshake: ev_valid stays high while the FIFO is not empty, and the
// head outputs hold still until a cycle with ev_valid & ev_ready pops the
// entry. ev_ready while ev_valid is low has no effect.
// -----------------------------------------------------------------------------
module keys_pio_service_ctrl #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [3:0]  INIT_MASK  = 4'hF
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   input  logic        pio_irq,
   input  logic [3:0]  cfg_mask,
   input  logic        cfg_mask_load,
   output logic        ev_valid,
   input  logic        ev_ready,
   output logic [1:0]  ev_key,
   output logic        ev_pressed,
   output logic        ev_overflow,
   input  logic        ev_overflow_clr,
   output logic        busy,
   output logic [3:0]  dbg_state_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [3:0] {
      ST_INIT     = 4'd0,
      ST_IDLE     = 4'd1,
      ST_MASK_WR  = 4'd2,
      ST_RD_CAP   = 4'd3,
      ST_CAP_WAIT = 4'd4,
      ST_CLR      = 4'd5,
      ST_RD_DAT   = 4'd6,
      ST_DAT_WAIT = 4'd7,
      ST_EMIT     = 4'd8
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [3:0]  cap_q, cap_d;
   logic [3:0]  lvl_q, lvl_d;
   logic [3:0]  mask_q, mask_d;
   logic        pending_q, pending_d;
   logic        push;
   logic [2:0]  push_data;

   logic        cs_d, wn_d;
   logic [1:0]  addr_d;
   logic [3:0]  wd_d;

   logic        unused_rd;
   assign unused_rd = ^m_readdata[31:4];

   // Next-state logic. A load strobe is visible in the same cycle, so a
   // strobe while IDLE issues MASK_WR on the very next cycle.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cap_d     = cap_q;
      lvl_d     = lvl_q;
      mask_d    = cfg_mask_load ? cfg_mask : mask_q;
      pending_d = pending_q | cfg_mask_load;
      push      = 1'b0;
      push_data = {idx_q, ~lvl_q[idx_q]};
      case (state_q)
         // Outputs are idle during reset, so INIT spends its first cycle
         // presenting the write and leaves once it has been on the bus.
         ST_INIT:     if (m_chipselect) state_d = ST_IDLE;
         ST_IDLE: begin
            if (pending_q || cfg_mask_load) begin
               state_d   = ST_MASK_WR;
               pending_d = 1'b0;
            end else if (pio_irq) begin
               state_d = ST_RD_CAP;
            end
         end
         ST_MASK_WR:  state_d = ST_IDLE;
         ST_RD_CAP:   state_d = ST_CAP_WAIT;
         ST_CAP_WAIT: begin
            cap_d   = m_readdata[3:0];
            state_d = ST_CLR;
         end
         ST_CLR:      state_d = ST_RD_DAT;
         ST_RD_DAT:   state_d = ST_DAT_WAIT;
         ST_DAT_WAIT: begin
            lvl_d   = m_readdata[3:0];
            idx_d   = 2'd0;
            state_d = ST_EMIT;
         end
         ST_EMIT: begin
            push  = cap_q[idx_q];
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = ST_IDLE;
         end
         default:     state_d = ST_INIT;
      endcase
   end

   // Bus outputs are registered from the state being entered, so they line
   // up with state_q in every cycle.
   always_comb begin
      cs_d   = 1'b0;
      wn_d   = 1'b1;
      addr_d = 2'd0;
      wd_d   = 4'h0;
      case (state_d)
         ST_INIT:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd2; wd_d = INIT_MASK; end
         ST_MASK_WR:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd2; wd_d = mask_d;    end
         ST_RD_CAP,
         ST_CAP_WAIT: begin cs_d = 1'b1; addr_d = 2'd3; end
         ST_CLR:      begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd3; wd_d = 4'hF;      end
         ST_RD_DAT,
         ST_DAT_WAIT: begin cs_d = 1'b1; addr_d = 2'd0; end
         default:     ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_INIT;
         idx_q        <= 2'd0;
         cap_q        <= 4'h0;
         lvl_q        <= 4'h0;
         mask_q       <= 4'h0;
         pending_q    <= 1'b0;
         m_address    <= 2'd0;
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_writedata  <= 32'd0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cap_q        <= cap_d;
         lvl_q        <= lvl_d;
         mask_q       <= mask_d;
         pending_q    <= pending_d;
         m_address    <= addr_d;
         m_chipselect <= cs_d;
         m_write_n    <= wn_d;
         m_writedata  <= {28'd0, wd_d};
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign dbg_state_o = state_q;

   // ---------------------------------------------------------------- FIFO
   logic [2:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          ovf_q;
   logic          full, pop, push_ok, drop;

   assign full    = (count_q == DEPTH_C);
   assign pop     = ev_valid & ev_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok = push & (~full | pop);
   assign drop    = push & full & ~pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: ;
         endcase
         if (drop)                 ovf_q <= 1'b1;
         else if (ev_overflow_clr) ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

   // Head is forced to zero when empty so stale entries never show.
   assign ev_valid    = (count_q != '0);
   assign ev_key      = ev_valid ? mem_q[rd_ptr_q][2:1] : 2'd0;
   assign ev_pressed  = ev_valid ? mem_q[rd_ptr_q][0]   : 1'b0;
   assign ev_overflow = ovf_q;

endmodule

// File: tb/tb_keys_pio_service_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for keys_pio_service_ctrl. A behavioural key PIO (edge capture with
// write-1-to-clear, registered read data) sits on the master port. Key level
// changes are applied to it; the expected event stream is derived from which
// keys changed and their new levels, in key-index order, bounded by the FIFO
// depth.
// -----------------------------------------------------------------------------
module tb_keys_pio_service_ctrl;
   localparam int DEPTH = 4;

   // ------------------------------------------------------ clock and reset
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // ------------------------------------------------------------ DUT wires
   logic [1:0]  m_address;
   logic        m_chipselect, m_write_n;
   logic [31:0] m_writedata, m_readdata;
   logic        pio_irq;
   logic [3:0]  cfg_mask;
   logic        cfg_mask_load;
   logic        ev_valid, ev_ready;
   logic [1:0]  ev_key;
   logic        ev_pressed, ev_overflow, ev_overflow_clr, busy;
   logic [3:0]  dbg_state;

   keys_pio_service_ctrl #(.FIFO_DEPTH(DEPTH), .INIT_MASK(4'hF)) dut (
      .clk(clk), .reset_n(reset_n),
      .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
      .m_writedata(m_writedata), .m_readdata(m_readdata), .pio_irq(pio_irq),
      .cfg_mask(cfg_mask), .cfg_mask_load(cfg_mask_load),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_key(ev_key),
      .ev_pressed(ev_pressed), .ev_overflow(ev_overflow),
      .ev_overflow_clr(ev_overflow_clr), .busy(busy), .dbg_state_o(dbg_state)
   );

   // ------------------------------------------------------ key PIO model
   logic [3:0] keys, keys_prev, edge_cap, pio_mask, pio_clr;

   assign pio_clr = (m_chipselect && !m_write_n && m_address == 2'd3) ? m_writedata[3:0] : 4'h0;
   assign pio_irq = |(edge_cap & pio_mask);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         keys_prev  <= keys;
         edge_cap   <= 4'h0;
         pio_mask   <= 4'h0;
         m_readdata <= 32'd0;
      end else begin
         keys_prev <= keys;
         edge_cap  <= (edge_cap | (keys ^ keys_prev)) & ~pio_clr;
         if (m_chipselect && !m_write_n && m_address == 2'd2) pio_mask <= m_writedata[3:0];
         if (m_chipselect && m_write_n) begin
            case (m_address)
               2'd0:    m_readdata <= {28'd0, keys};
               2'd2:    m_readdata <= {28'd0, pio_mask};
               2'd3:    m_readdata <= {28'd0, edge_cap};
               default: m_readdata <= 32'd0;
            endcase
         end
      end
   end

   // ------------------------------------------------- scoreboard / model
   logic [2:0] exp_q[$];
   logic       exp_ovf;
   int         checks;
   int         errors;

   // Every key whose level differs yields {key, new level == 0}, lowest key
   // first; entries beyond the FIFO depth are lost and flag overflow.
   function automatic void model_change(input logic [3:0] old_l, input logic [3:0] new_l);
      for (int i = 0; i < 4; i++) begin
         if (old_l[i] != new_l[i]) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({2'(i), ~new_l[i]});
            else                      exp_ovf = 1'b1;
         end
      end
   endfunction

   // ------------------------------------------------------- driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_keys(input logic [3:0] nk);
      model_change(keys, nk);
      keys = nk;
   endtask

   // Advance until the edge-capture read (RD_CAP) is on the bus.
   task automatic wait_rdcap(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (m_chipselect && m_write_n && m_address == 2'd3) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic wait_idle(output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         step();
         n++;
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      int writes;
      reset_n = 1'b0;
      repeat (3) step();
      checks++; if ({m_chipselect, m_write_n, m_address} !== 4'b0100) begin errors++;
         $display("FAIL reset_bus got cs=%0b wn=%0b addr=%0d exp cs=0 wn=1 addr=0", m_chipselect, m_write_n, m_address); end
      checks++; if (m_writedata !== 32'd0) begin errors++;
         $display("FAIL reset_wdata got=%h exp=0", m_writedata); end
      checks++; if ({ev_valid, ev_key, ev_pressed, ev_overflow} !== 5'b0) begin errors++;
         $display("FAIL reset_ev got v=%0b k=%0d p=%0b o=%0b exp all 0", ev_valid, ev_key, ev_pressed, ev_overflow); end
      checks++; if (busy !== 1'b1) begin errors++;
         $display("FAIL reset_busy got=%0b exp=1", busy); end
      reset_n = 1'b1;
      step();
      checks++; if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b1, 1'b0, 2'd2, 32'hF}) begin errors++;
         $display("FAIL init_write got cs=%0b wn=%0b addr=%0d wd=%h exp cs=1 wn=0 addr=2 wd=f", m_chipselect, m_write_n, m_address, m_writedata); end
      step();
      checks++; if ({busy, m_chipselect} !== 2'b00) begin errors++;
         $display("FAIL init_done got busy=%0b cs=%0b exp 0 0", busy, m_chipselect); end
      writes = 0;
      repeat (5) begin
         if (m_chipselect) writes++;
         step();
      end
      checks++; if (writes != 0) begin errors++;
         $display("FAIL init_single_write got extra accesses=%0d exp=0", writes); end
      checks++; if (pio_mask !== 4'hF) begin errors++;
         $display("FAIL init_mask got=%h exp=f", pio_mask); end
   endtask

   task automatic test_key2_press();
      bit ok;
      logic [4:0] exp_bus [10];
      logic [2:0] e;
      // {chipselect, write_n, address, busy} from RD_CAP through return to IDLE
      exp_bus = '{5'b11111, 5'b11111, 5'b10111, 5'b11001, 5'b11001,
                  5'b01001, 5'b01001, 5'b01001, 5'b01001, 5'b01000};
      apply_keys(4'hB);
      wait_rdcap(ok);
      checks++; if (!ok) begin errors++; $display("FAIL key2_start got no RD_CAP exp RD_CAP within 40 cycles"); end
      for (int k = 0; k < 10; k++) begin
         checks++; if ({m_chipselect, m_write_n, m_address, busy} !== exp_bus[k]) begin errors++;
            $display("FAIL key2_bus cycle=%0d got=%b exp=%b", k, {m_chipselect, m_write_n, m_address, busy}, exp_bus[k]); end
         if (k == 2) begin
            checks++; if (m_writedata !== 32'hF) begin errors++; $display("FAIL key2_clr_data got=%h exp=f", m_writedata); end
         end
         if (k == 3) begin
            checks++; if (pio_irq !== 1'b0) begin errors++; $display("FAIL key2_irq_cleared got=%0b exp=0", pio_irq); end
         end
         if (k == 7 || k == 8) begin
            checks++; if (ev_valid !== (k == 8)) begin errors++; $display("FAIL key2_ev_timing cycle=%0d got=%0b exp=%0b", k, ev_valid, (k == 8)); end
         end
         if (k < 9) step();
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++; if (!(ev_valid === 1'b1 && {ev_key, ev_pressed} === e)) begin errors++;
            $display("FAIL key2_event got v=%0b k=%0d p=%0b exp k=%0d p=%0b", ev_valid, ev_key, ev_pressed, e[2:1], e[0]); end
         ev_ready = 1'b1; step(); ev_ready = 1'b0;
      end
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL key2_empty got=%0b exp=0", ev_valid); end
   endtask

   task automatic test_simultaneous();
      bit ok, ok2;
      int n;
      logic [2:0] e;
      apply_keys(4'hE);
      wait_rdcap(ok); wait_idle(ok2, n);
      apply_keys(4'h7);
      wait_rdcap(ok); wait_idle(ok2, n);
      checks++; if (!(ok && ok2 && n == 9)) begin errors++;
         $display("FAIL simul_service_len got ok=%0b/%0b cycles=%0d exp 9", ok, ok2, n); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++; if (!(ev_valid === 1'b1 && {ev_key, ev_pressed} === e)) begin errors++;
            $display("FAIL simul_event got v=%0b k=%0d p=%0b exp k=%0d p=%0b", ev_valid, ev_key, ev_pressed, e[2:1], e[0]); end
         ev_ready = 1'b1; step(); ev_ready = 1'b0;
      end
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL simul_empty got=%0b exp=0", ev_valid); end
   endtask

   task automatic test_random_keys();
      bit ok, ok2;
      int n;
      logic [3:0] nk;
      logic [2:0] e;
      for (int it = 0; it < 10; it++) begin
         do nk = 4'($urandom_range(0, 15)); while (nk == keys);
         apply_keys(nk);
         wait_rdcap(ok); wait_idle(ok2, n);
         checks++; if (!(ok && ok2)) begin errors++; $display("FAIL rand_service it=%0d got ok=%0b/%0b exp 1/1", it, ok, ok2); end
         repeat ($urandom_range(0, 3)) step();
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (!(ev_valid === 1'b1 && {ev_key, ev_pressed} === e)) begin errors++;
               $display("FAIL rand_event it=%0d got v=%0b k=%0d p=%0b exp k=%0d p=%0b", it, ev_valid, ev_key, ev_pressed, e[2:1], e[0]); end
            ev_ready = 1'b1; step(); ev_ready = 1'b0;
         end
      end
      checks++; if ({ev_valid, ev_overflow} !== 2'b00) begin errors++;
         $display("FAIL rand_final got v=%0b o=%0b exp 0 0", ev_valid, ev_overflow); end
   endtask

   task automatic test_overflow();
      bit ok, ok2;
      int n;
      logic [1:0] b;
      logic [2:0] e;
      ev_ready = 1'b0;
      for (int s = 0; s < 6; s++) begin
         b = 2'($urandom_range(0, 3));
         apply_keys(keys ^ (4'h1 << b));
         wait_rdcap(ok); wait_idle(ok2, n);
         checks++; if (!(ok && ok2) || ev_overflow !== exp_ovf) begin errors++;
            $display("FAIL ovf_flag svc=%0d got=%0b exp=%0b ok=%0b/%0b", s, ev_overflow, exp_ovf, ok, ok2); end
      end
      ev_overflow_clr = 1'b1; step(); ev_overflow_clr = 1'b0;
      exp_ovf = 1'b0;
      checks++; if (ev_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b exp=0", ev_overflow); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++; if (!(ev_valid === 1'b1 && {ev_key, ev_pressed} === e)) begin errors++;
            $display("FAIL ovf_event got v=%0b k=%0d p=%0b exp k=%0d p=%0b", ev_valid, ev_key, ev_pressed, e[2:1], e[0]); end
         ev_ready = 1'b1; step(); ev_ready = 1'b0;
      end
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%0b exp=0", ev_valid); end
   endtask

   task automatic test_full_push_pop();
      bit ok, ok2;
      int n;
      logic [1:0] b;
      logic [3:0] nk;
      logic [2:0] e;
      ev_ready = 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
         apply_keys(keys ^ (4'h1 << 2'(s)));
         wait_rdcap(ok); wait_idle(ok2, n);
      end
      b  = 2'($urandom_range(0, 3));
      nk = keys ^ (4'h1 << b);
      keys = nk;
      wait_rdcap(ok);
      repeat (5 + int'(b)) step();
      // This is the EMIT cycle for key b: pop while the FIFO is full.
      e = exp_q.pop_front();
      checks++; if (!(ev_valid === 1'b1 && {ev_key, ev_pressed} === e)) begin errors++;
         $display("FAIL fpp_head got v=%0b k=%0d p=%0b exp k=%0d p=%0b", ev_valid, ev_key, ev_pressed, e[2:1], e[0]); end
      ev_ready = 1'b1; step(); ev_ready = 1'b0;
      exp_q.push_back({b, ~nk[b]});
      wait_idle(ok2, n);
      checks++; if (!(ok && ok2) || ev_overflow !== 1'b0) begin errors++;
         $display("FAIL fpp_no_drop got ovf=%0b ok=%0b/%0b exp ovf=0", ev_overflow, ok, ok2); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++; if (!(ev_valid === 1'b1 && {ev_key, ev_pressed} === e)) begin errors++;
            $display("FAIL fpp_event got v=%0b k=%0d p=%0b exp k=%0d p=%0b", ev_valid, ev_key, ev_pressed, e[2:1], e[0]); end
         ev_ready = 1'b1; step(); ev_ready = 1'b0;
      end
   endtask

   task automatic test_mask_load();
      bit ok, ok2;
      int n;
      logic [2:0] e;
      apply_keys(keys ^ 4'h1);
      wait_rdcap(ok);
      step();                                  // CAP_WAIT
      cfg_mask = 4'h3; cfg_mask_load = 1'b1;
      step();
      cfg_mask_load = 1'b0;
      repeat (4) step();                       // after CLR: new edge on key1
      apply_keys(keys ^ 4'h2);
      wait_idle(ok2, n);
      checks++; if (!(ok && ok2 && n == 3)) begin errors++;
         $display("FAIL mask_service got ok=%0b/%0b cycles=%0d exp 3", ok, ok2, n); end
      step();
      checks++; if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b1, 1'b0, 2'd2, 32'h3}) begin errors++;
         $display("FAIL mask_write got cs=%0b wn=%0b addr=%0d wd=%h exp cs=1 wn=0 addr=2 wd=3", m_chipselect, m_write_n, m_address, m_writedata); end
      step();
      checks++; if ({busy, m_chipselect} !== 2'b00) begin errors++;
         $display("FAIL mask_back_idle got busy=%0b cs=%0b exp 0 0", busy, m_chipselect); end
      step();
      checks++; if ({m_chipselect, m_write_n, m_address} !== 4'b1111 || pio_mask !== 4'h3) begin errors++;
         $display("FAIL mask_then_irq got cs=%0b wn=%0b addr=%0d pio_mask=%h exp read 3, mask 3", m_chipselect, m_write_n, m_address, pio_mask); end
      wait_idle(ok2, n);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++; if (!(ev_valid === 1'b1 && {ev_key, ev_pressed} === e)) begin errors++;
            $display("FAIL mask_event got v=%0b k=%0d p=%0b exp k=%0d p=%0b", ev_valid, ev_key, ev_pressed, e[2:1], e[0]); end
         ev_ready = 1'b1; step(); ev_ready = 1'b0;
      end
      cfg_mask = 4'hF; cfg_mask_load = 1'b1;
      step();
      cfg_mask_load = 1'b0;
      checks++; if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b1, 1'b0, 2'd2, 32'hF}) begin errors++;
         $display("FAIL mask_idle_latency got cs=%0b wn=%0b addr=%0d wd=%h exp cs=1 wn=0 addr=2 wd=f", m_chipselect, m_write_n, m_address, m_writedata); end
      repeat (2) step();
   endtask

   task automatic test_reset_mid_service();
      bit ok, ok2;
      int n;
      ev_ready = 1'b0;
      apply_keys(keys ^ 4'h3);
      wait_rdcap(ok); wait_idle(ok2, n);
      checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL rst_queued got=%0b exp=1", ev_valid); end
      keys = keys ^ 4'h4;
      wait_rdcap(ok);
      repeat (4) step();                       // DAT_WAIT
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      checks++; if ({ev_valid, ev_key, ev_pressed, ev_overflow, busy} !== 6'b000001) begin errors++;
         $display("FAIL rst_mid_ev got v=%0b k=%0d p=%0b o=%0b busy=%0b exp 0 0 0 0 1", ev_valid, ev_key, ev_pressed, ev_overflow, busy); end
      checks++; if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin errors++;
         $display("FAIL rst_mid_bus got cs=%0b wn=%0b addr=%0d wd=%h exp 0 1 0 0", m_chipselect, m_write_n, m_address, m_writedata); end
      repeat (2) step();
      reset_n = 1'b1;
      step();
      checks++; if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b1, 1'b0, 2'd2, 32'hF}) begin errors++;
         $display("FAIL rst_reinit got cs=%0b wn=%0b addr=%0d wd=%h exp cs=1 wn=0 addr=2 wd=f", m_chipselect, m_write_n, m_address, m_writedata); end
      step();
      checks++; if ({busy, ev_valid} !== 2'b00) begin errors++;
         $display("FAIL rst_after got busy=%0b v=%0b exp 0 0", busy, ev_valid); end
   endtask

   // ------------------------------------------------------------ sequence
   initial begin
      checks = 0; errors = 0; exp_ovf = 1'b0;
      reset_n = 1'b0; keys = 4'hF;
      cfg_mask = 4'h0; cfg_mask_load = 1'b0;
      ev_ready = 1'b0; ev_overflow_clr = 1'b0;
      test_reset();
      test_key2_press();
      test_simultaneous();
      test_random_keys();
      test_overflow();
      test_full_push_pop();
      test_mask_load();
      test_reset_mid_service();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog got no completion exp finish before 300000");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/keys_pio_service_ctrl.md
# keys_pio_service_ctrl

Avalon-MM master controller that owns the 4-bit key PIO slave (data at address 0, IRQ mask at 2, edge capture at 3). It programs the PIO interrupt mask, services its IRQ by reading and clearing edge capture, and samples key levels. It converts each captured edge into a press/release event in a small FIFO for the synthesizer note logic, so the Nios software does not have to touch the keys.

## Interface
Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of two, 2..16.
- INIT_MASK, 4'hF: IRQ mask written to the PIO after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m_address  out  2  PIO register address.
- m_chipselect  out  1  PIO chipselect.
- m_write_n  out  1  active-low write strobe.
- m_writedata  out  32  write data, {28'b0, value[3:0]}.
- m_readdata  in  32  PIO read data; registered in the PIO, valid the cycle after the address; only [3:0] used.
- pio_irq  in  1  PIO interrupt (OR of edge_capture & irq_mask).
- cfg_mask  in  4  new IRQ mask value.
- cfg_mask_load  in  1  one-cycle strobe requesting a mask write.
- ev_valid  out  1  event FIFO not empty.
- ev_ready  in  1  consumer pop; pop occurs when ev_valid & ev_ready.
- ev_key  out  2  key index of the head event.
- ev_pressed  out  1  1 = key pressed (PIO level 0, keys are active-low), 0 = released.
- ev_overflow  out  1  sticky: at least one event was dropped because the FIFO was full.
- ev_overflow_clr  in  1  clears ev_overflow; a same-cycle drop wins.
- busy  out  1  1 in every state except IDLE.

## Operation
FSM states and outputs (m_chipselect=1 and address as listed, otherwise chipselect=0, write_n=1, address=0):
- INIT: write INIT_MASK to address 2. -> IDLE.
- IDLE: priority is pending mask load first, then pio_irq=1 -> RD_CAP, else stay.
- MASK_WR: write the latched cfg_mask to address 2, clear pending. -> IDLE.
- RD_CAP: read address 3. -> CAP_WAIT.
- CAP_WAIT: hold address 3; capture m_readdata[3:0] into cap at cycle end. -> CLR.
- CLR: write 4'hF to address 3, clearing edge capture. -> RD_DAT.
- RD_DAT: read address 0. -> DAT_WAIT.
- DAT_WAIT: hold address 0; capture m_readdata[3:0] into lvl. -> EMIT.
- EMIT: 4 cycles, idx = 0..3. If cap[idx]=1, push {idx, ~lvl[idx]}. -> IDLE after idx=3.

Rules:
- cfg_mask_load in any state latches cfg_mask and sets the pending flag. A later load before service overwrites the value; only one write is issued.
- FIFO push when full: the event is dropped and ev_overflow is set. Push and pop in the same cycle while full is accepted, with no drop.
- Pop when empty is ignored. Head outputs are held stable while ev_valid=1 and no pop occurs.
- An edge that reaches the PIO in the cycle its CLR write is accepted is lost. This is an accepted limitation.
- An edge arriving after CLR re-asserts pio_irq and is serviced on the next IDLE.
- Reset in any state aborts the access and empties the FIFO. The FSM restarts in INIT.

## Timing
Reset values:
- m_address=0, m_chipselect=0, m_write_n=1, m_writedata=0.
- ev_valid=0, ev_key=0, ev_pressed=0, ev_overflow=0, busy=1.
- FSM=INIT, pending=0.

Latencies:
- The INIT write occurs in the first clock after reset deassertion. IDLE is reached on the next cycle.
- With pio_irq=1 in IDLE at cycle T: RD_CAP at T+1, CLR at T+3, EMIT idx0 at T+6, IDLE at T+10. A service is 9 cycles.
- A pushed event sets ev_valid the cycle after its EMIT cycle, so there is no fall-through.
- Mask write: the load strobe in IDLE at cycle T gives MASK_WR at T+1.
- Each PIO access is a single cycle; the PIO has no waitrequest.

## Test plan
- Reset release: exactly one write, address 2, data 0xF, then busy=0 with m_chipselect=0.
- KEY2 press: PIO capture 0x4, level 0xB. Expect cycle sequence read3, read3, write3 (0xF), read0, read0. Then one event: key=2, pressed=1. pio_irq is low after CLR.
- Simultaneous KEY0 release and KEY3 press: capture 0x9, level 0x7. Expect events in order (0,0) then (3,1), 9 cycles from IRQ to IDLE.
- Overflow: FIFO_DEPTH=4, ev_ready=0, six single-key services. Expect 4 events retained in order and ev_overflow=1. ev_overflow_clr clears it, and the subsequent pops return the first 4 events.
- Mask load during service: cfg_mask=0x3 pulsed in CAP_WAIT. Expect MASK_WR (address 2, data 0x3) immediately after return to IDLE, before any new IRQ service.
- Reset asserted in DAT_WAIT with 2 events queued: expect ev_valid=0 and outputs at reset values. After release, the INIT write reoccurs.
